// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, stop-bit check.
// Good bytes get a 1-cycle rx_valid; a low stop bit gives frame_err and waits out a break.
module uart_rx #(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int DIV_CNT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT = DIV_CNT / 2;
    localparam logic [15:0] DIV_LAST  = 16'(DIV_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        rx_m_q, rx_s_q;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    div_d   = '0;
                end
            end
            START: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            STOP: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            BREAK: begin
                // Held-low line must return high before a new frame is armed
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
